spi_cmd_arbiter: RTL

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

---
 rtl/spi_cmd_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter that lets three requesters share one SPI frame engine.
// One transaction at a time: IDLE -> START -> BUSY -> DONE, with a BUSY watchdog.
module spi_cmd_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] req_cmd,
    input  logic [47:0] req_addr,
    input  logic [47:0] req_len,
    input  logic [23:0] req_dat,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        err,
    output logic [2:0]  rdreq_o,
    output logic [2:0]  den_o,
    output logic [7:0]  dout,
    output logic        o_start,
    output logic [7:0]  o_cmd,
    output logic [15:0] o_addr,
    output logic [15:0] o_length,
    output logic [7:0]  o_dat,
    input  logic        rdreq,
    input  logic        den,
    input  logic [7:0]  din,
    input  logic        wrend,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  sel, last, pick;
    logic [1:0]  cand0, cand1;
    logic [15:0] cnt;
    logic        to_flag;
    logic        to_hit;
    logic [7:0]  cmd_q;
    logic [15:0] addr_q, len_q;

    logic [7:0]  cmd_a  [3];
    logic [15:0] addr_a [3];
    logic [15:0] len_a  [3];
    logic [7:0]  dat_a  [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cmd_a[i]  = req_cmd[8*i +: 8];
            addr_a[i] = req_addr[16*i +: 16];
            len_a[i]  = req_len[16*i +: 16];
            dat_a[i]  = req_dat[8*i +: 8];
        end
    end

    // Search order starts one past the last served requester, wrapping mod 3.
    always_comb begin
        cand0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
        if (req[cand0])      pick = cand0;
        else if (req[cand1]) pick = cand1;
        else                 pick = last;
    end

    assign to_hit = (cnt == TIMEOUT_CYC - 16'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (wrend || to_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 2'd2;
            sel     <= 2'd0;
            cnt     <= 16'd0;
            to_flag <= 1'b0;
            cmd_q   <= 8'd0;
            addr_q  <= 16'd0;
            len_q   <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel    <= pick;
                        cmd_q  <= cmd_a[pick];
                        addr_q <= addr_a[pick];
                        len_q  <= len_a[pick];
                    end
                    to_flag <= 1'b0;
                end
                START: cnt <= 16'd0;
                BUSY: begin
                    cnt <= cnt + 16'd1;
                    // wrend on the watchdog's final cycle still counts as a clean finish
                    if (to_hit && !wrend) to_flag <= 1'b1;
                end
                DONE: begin
                    last    <= sel;
                    to_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt      = 3'b000;
        done     = 3'b000;
        err      = 1'b0;
        rdreq_o  = 3'b000;
        den_o    = 3'b000;
        o_start  = 1'b0;
        o_cmd    = 8'd0;
        o_addr   = 16'd0;
        o_length = 16'd0;
        o_dat    = 8'd0;
        case (state)
            START: begin
                gnt[sel] = 1'b1;
                o_start  = 1'b1;
                o_cmd    = cmd_q;
                o_addr   = addr_q;
                o_length = len_q;
            end
            BUSY: begin
                gnt[sel]     = 1'b1;
                o_cmd        = cmd_q;
                o_addr       = addr_q;
                o_length     = len_q;
                o_dat        = dat_a[sel];
                rdreq_o[sel] = rdreq;
                den_o[sel]   = den;
            end
            DONE: begin
                gnt[sel]  = 1'b1;
                done[sel] = 1'b1;
                err       = to_flag;
            end
            default: ;
        endcase
    end

    assign dout      = din;
    assign fsm_state = state;

endmodule
